// File: rtl/bam_write_arbiter.sv
// bam_write_arbiter: two-port round-robin write arbiter for the BAM with a full-screen clear engine
module bam_write_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8,
  parameter int CELLS = 4800,
  parameter logic [DATA_W-1:0] BLANK_CHAR = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data,
  output logic              m0_ready,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data,
  output logic              m1_ready,
  output logic              bam_we,
  output logic [ADDR_W-1:0] bam_addr,
  output logic [DATA_W-1:0] bam_wdata,
  output logic [7:0]        drop_cnt
);
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  logic [0:0] state;
  logic [ADDR_W-1:0] ptr;
  logic last_m1;
  logic open;
  logic hs;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic ptr_end;
  // Grant: clear request pre-empts everything; on a tie the port not granted last wins
  always_comb begin
    open = (state == RUN) && !clr_req;
    m0_ready = open && m0_valid && (!m1_valid || last_m1);
    m1_ready = open && m1_valid && (!m0_valid || !last_m1);
    hs = m0_ready || m1_ready;
    sel_addr = m1_ready ? m1_addr : m0_addr;
    sel_data = m1_ready ? m1_data : m0_data;
    ptr_end = ptr == ADDR_W'(CELLS - 1);
    clr_busy = state == CLEAR;
  end
  // Registered BAM write port, clear sweep, round-robin history and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      ptr <= '0;
      last_m1 <= 1'b1;
      bam_we <= 1'b0;
      bam_addr <= '0;
      bam_wdata <= '0;
      drop_cnt <= '0;
    end else if (state == CLEAR) begin
      bam_we <= 1'b1;
      bam_addr <= ptr;
      bam_wdata <= BLANK_CHAR;
      ptr <= ptr_end ? '0 : ptr + 1'b1;
      state <= ptr_end ? RUN : CLEAR;
    end else if (clr_req) begin
      state <= CLEAR;
      ptr <= '0;
      bam_we <= 1'b0;
    end else if (hs) begin
      last_m1 <= m1_ready;
      bam_we <= sel_addr < ADDR_W'(CELLS);
      bam_addr <= sel_addr < ADDR_W'(CELLS) ? sel_addr : bam_addr;
      bam_wdata <= sel_addr < ADDR_W'(CELLS) ? sel_data : bam_wdata;
      drop_cnt <= (sel_addr >= ADDR_W'(CELLS) && drop_cnt != 8'hff) ? drop_cnt + 8'd1 : drop_cnt;
    end else begin
      bam_we <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bam_write_arbiter.sv
// tb_bam_write_arbiter: directed-vector check of arbitration, clear engine, drops and reset
module tb_bam_write_arbiter;
  localparam int CELLS = 4800;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_req = 1'b0;
  logic clr_busy;
  logic m0_valid = 1'b0;
  logic [12:0] m0_addr = '0;
  logic [7:0] m0_data = '0;
  logic m0_ready;
  logic m1_valid = 1'b0;
  logic [12:0] m1_addr = '0;
  logic [7:0] m1_data = '0;
  logic m1_ready;
  logic bam_we;
  logic [12:0] bam_addr;
  logic [7:0] bam_wdata;
  logic [7:0] drop_cnt;
  int vecs = 0;
  int errs = 0;
  int busy, bad, good, wr;

  bam_write_arbiter dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(clr_busy),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_data(m0_data), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_data(m1_data), .m1_ready(m1_ready),
    .bam_we(bam_we), .bam_addr(bam_addr), .bam_wdata(bam_wdata), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #12;
    chk("rst_we", bam_we, 0);
    chk("rst_addr", bam_addr, 0);
    chk("rst_wdata", bam_wdata, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    cyc;
    m0_valid = 1'b1; m0_addr = 13; m0_data = 8'h11;
    #1;
    chk("single_r0", m0_ready, 1);
    chk("single_r1", m1_ready, 0);
    cyc;
    m0_valid = 1'b0;
    chk("single_we", bam_we, 1);
    chk("single_addr", bam_addr, 13);
    chk("single_data", bam_wdata, 8'h11);
    cyc;
    chk("single_we_off", bam_we, 0);
    chk("single_hold", bam_addr, 13);
    do_rst;
    m0_valid = 1'b1; m0_addr = 100; m0_data = 8'h21;
    m1_valid = 1'b1; m1_addr = 200; m1_data = 8'h22;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_r0", m0_ready, (i % 2 == 0));
      chk("rr_r1", m1_ready, (i % 2 == 1));
      cyc;
      chk("rr_addr", bam_addr, (i % 2 == 0) ? 100 : 200);
      chk("rr_data", bam_wdata, (i % 2 == 0) ? 8'h21 : 8'h22);
    end
    m0_valid = 1'b0;
    m1_addr = 5; m1_data = 8'h33; clr_req = 1'b1;
    #1;
    chk("clr_prio", m1_ready, 0);
    cyc;
    clr_req = 1'b0;
    busy = 0; bad = 0; good = 0;
    for (int k = 1; k <= CELLS; k++) begin
      if (k > 1) cyc;
      busy += int'(clr_busy);
      bad += int'(m0_ready | m1_ready);
      if (k == 1 && bam_we) bad++;
      if (k >= 2 && bam_we && bam_addr == 13'(k - 2) && bam_wdata == 8'h00) good++;
    end
    cyc;
    chk("clr_busy_cycles", busy, CELLS);
    chk("clr_ready_bad", bad, 0);
    chk("clr_seq_writes", good, CELLS - 1);
    chk("clr_done_busy", clr_busy, 0);
    chk("clr_last_we", bam_we, 1);
    chk("clr_last_addr", bam_addr, CELLS - 1);
    chk("clr_resume_r1", m1_ready, 1);
    cyc;
    chk("resume_we", bam_we, 1);
    chk("resume_addr", bam_addr, 5);
    chk("resume_data", bam_wdata, 8'h33);
    m1_addr = 4800; m1_data = 8'h44;
    #1;
    chk("oor_r1", m1_ready, 1);
    cyc;
    chk("oor_we", bam_we, 0);
    chk("oor_drop1", drop_cnt, 1);
    repeat (299) cyc;
    m1_valid = 1'b0;
    chk("oor_sat", drop_cnt, 255);
    chk("oor_we2", bam_we, 0);
    chk("oor_hold", bam_addr, 5);
    clr_req = 1'b1;
    cyc;
    clr_req = 1'b0;
    busy = 0; wr = 0;
    for (int k = 1; k <= CELLS + 3; k++) begin
      if (k > 1) cyc;
      busy += int'(clr_busy);
      wr += int'(bam_we);
      if (k == 1001) clr_req = 1'b1;
      if (k == 1002) clr_req = 1'b0;
    end
    chk("reclr_busy", busy, CELLS);
    chk("reclr_writes", wr, CELLS);
    clr_req = 1'b1;
    cyc;
    clr_req = 1'b0;
    for (int k = 2; k <= 2001; k++) cyc;
    chk("mid_busy_before", clr_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", bam_we, 0);
    chk("mid_rst_busy", clr_busy, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    #2;
    rst_n = 1'b1;
    wr = 0; busy = 0;
    repeat (10) begin
      cyc;
      wr += int'(bam_we);
      busy += int'(clr_busy);
    end
    chk("post_rst_writes", wr, 0);
    chk("post_rst_busy", busy, 0);
    m0_valid = 1'b1; m0_addr = 42; m0_data = 8'h55;
    #1;
    chk("post_rst_r0", m0_ready, 1);
    cyc;
    m0_valid = 1'b0;
    chk("post_rst_we", bam_we, 1);
    chk("post_rst_addr", bam_addr, 42);
    chk("post_rst_data", bam_wdata, 8'h55);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
